// File: rtl/key_event_uart_reporter_pkg.sv
// Shared types and constants for the multi-key UART event reporter.
package key_pkg;
  localparam int KEY_IDX_W = 4;
  localparam int CNT_W     = 8;
  localparam logic [2:0] HDR_EVT = 3'b000;
  localparam logic [2:0] HDR_CNT = 3'b001;

  typedef enum logic [1:0] {IDLE, WAIT0, SEND1, WAIT1} tx_state_t;

  typedef struct packed {
    logic                 press;
    logic [KEY_IDX_W-1:0] idx;
    logic [CNT_W-1:0]     cnt;
  } evt_t;
endpackage

// File: rtl/key_event_uart_reporter_if.sv
// Byte handshake between the reporter and an external uart_byte_tx.
interface key_event_uart_reporter_if;
  logic [7:0] data_byte;
  logic       send_en;
  logic       tx_done;

  modport master (output data_byte, send_en, input tx_done);
  modport slave  (input data_byte, send_en, output tx_done);
endinterface

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus stable-time counter for one active-low key.
module key_debounce #(
  parameter int DB_CYC = 4
) (
  input  logic Clk,
  input  logic Rst,
  input  logic key_raw,
  output logic key_state,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(DB_CYC + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYC - 1);

  logic          sync_p0, sync_p1;
  logic [CW-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync_p0   <= 1'b1;
      sync_p1   <= 1'b1;
      key_state <= 1'b1;
      cnt       <= '0;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      sync_p0 <= key_raw;
      sync_p1 <= sync_p0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      if (sync_p1 == key_state) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        // DB_CYC consecutive disagreeing cycles: accept the new level
        cnt       <= '0;
        key_state <= sync_p1;
        rise      <= sync_p1;
        fall      <= ~sync_p1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/key_event_uart_reporter.sv
// N-key debounce, press counters, pending slots, event FIFO and a byte
// sequencer that reports key events or press counts over a UART byte link.
module key_event_uart_reporter
  import key_pkg::*;
#(
  parameter int NUM_KEYS    = 4,
  parameter int CLK_HZ      = 50000000,
  parameter int DEBOUNCE_MS = 20,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic [NUM_KEYS-1:0]           key_in,
  input  logic                          mode,
  input  logic                          cnt_clr,
  key_event_uart_reporter_if.master     bus,
  output logic [NUM_KEYS-1:0]           key_state,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);
  localparam int DB_CYC = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int AW     = $clog2(FIFO_DEPTH);

  logic [NUM_KEYS-1:0] rise, fall;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(.DB_CYC(DB_CYC)) u_db (
      .Clk      (Clk),
      .Rst      (Rst),
      .key_raw  (key_in[k]),
      .key_state(key_state[k]),
      .rise     (rise[k]),
      .fall     (fall[k])
    );
  end

  // Stage p1: counters and pending slots capture the event one cycle after key_state moves
  logic [CNT_W-1:0]    press_cnt     [NUM_KEYS];
  logic [CNT_W-1:0]    press_cnt_nxt [NUM_KEYS];
  logic [NUM_KEYS-1:0] pend_vld, pend_press, grant;
  logic [CNT_W-1:0]    pend_cnt [NUM_KEYS];
  logic                fifo_full, push, pop;
  evt_t                push_evt, head;

  always_comb begin
    for (int k = 0; k < NUM_KEYS; k++)
      press_cnt_nxt[k] = (cnt_clr ? '0 : press_cnt[k]) + CNT_W'(fall[k]);
  end

  always_ff @(posedge Clk) begin
    for (int k = 0; k < NUM_KEYS; k++)
      if (Rst) press_cnt[k] <= '0;
      else     press_cnt[k] <= press_cnt_nxt[k];
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pend_vld <= '0;
      overflow <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (rise[k] | fall[k]) begin
          pend_vld[k] <= 1'b1;
          if (pend_vld[k] && !(push && grant[k])) overflow <= 1'b1;
        end else if (push && grant[k]) begin
          pend_vld[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    for (int k = 0; k < NUM_KEYS; k++)
      if (rise[k] | fall[k]) begin
        pend_press[k] <= fall[k];
        pend_cnt[k]   <= press_cnt_nxt[k];
      end
  end

  // Stage p2: lowest-index pending slot moves into the FIFO
  always_comb begin
    grant    = pend_vld & (~pend_vld + NUM_KEYS'(1));
    push     = (|pend_vld) && !fifo_full;
    push_evt = '0;
    for (int k = 0; k < NUM_KEYS; k++)
      if (grant[k]) begin
        push_evt.press = pend_press[k];
        push_evt.idx   = KEY_IDX_W'(k);
        push_evt.cnt   = pend_cnt[k];
      end
  end

  evt_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;

  assign fifo_full = (fifo_level == (AW+1)'(FIFO_DEPTH));
  assign head      = mem[rptr];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (push) mem[wptr] <= push_evt;
  end

  // Stage p3: byte sequencer pops in IDLE and hands bytes to the UART
  tx_state_t  state, state_nxt;
  logic       send_nxt, load, mode_q, mode_nxt, tx_ack;
  logic [7:0] byte_nxt;
  logic [CNT_W-1:0] cnt_q;

  assign tx_ack = bus.tx_done && !bus.send_en;

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    send_nxt  = 1'b0;
    byte_nxt  = bus.data_byte;
    mode_nxt  = mode_q;
    unique case (state)
      IDLE: if (fifo_level != '0) begin
        pop = 1'b1;
        // count reports skip releases entirely
        if (!(mode && !head.press)) begin
          load      = 1'b1;
          send_nxt  = 1'b1;
          mode_nxt  = mode;
          byte_nxt  = mode ? {1'b1, HDR_CNT, head.idx} : {head.press, HDR_EVT, head.idx};
          state_nxt = WAIT0;
        end
      end
      WAIT0: if (tx_ack) state_nxt = mode_q ? SEND1 : IDLE;
      SEND1: begin
        byte_nxt  = cnt_q;
        send_nxt  = 1'b1;
        state_nxt = WAIT1;
      end
      WAIT1: if (tx_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      bus.send_en   <= 1'b0;
      bus.data_byte <= '0;
      mode_q        <= 1'b0;
    end else begin
      bus.send_en   <= send_nxt;
      bus.data_byte <= byte_nxt;
      mode_q        <= mode_nxt;
    end
  end

  always_ff @(posedge Clk) begin
    if (load) cnt_q <= head.cnt;
  end
endmodule

// File: tb/tb_key_event_uart_reporter.sv
// Directed bench for key_event_uart_reporter with a 10-cycle tx_done responder.
module tb_key_event_uart_reporter;
  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [3:0] key_in = 4'hF;
  logic       mode = 1'b0;
  logic       cnt_clr = 1'b0;
  logic [3:0] key_state;
  logic [3:0] fifo_level;
  logic       overflow;
  logic       tx_en = 1'b1;

  key_event_uart_reporter_if bus();

  key_event_uart_reporter #(
    .NUM_KEYS(4), .CLK_HZ(1000), .DEBOUNCE_MS(4), .FIFO_DEPTH(8)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .key_in    (key_in),
    .mode      (mode),
    .cnt_clr   (cnt_clr),
    .bus       (bus),
    .key_state (key_state),
    .fifo_level(fifo_level),
    .overflow  (overflow)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] sent[$];
  int max_lvl = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_byte(input int i);
    if (i < sent.size()) return {24'b0, sent[i]};
    return 32'hDEAD;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  always @(negedge Clk) begin
    if (bus.send_en === 1'b1) sent.push_back(bus.data_byte);
    if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
  end

  initial begin
    bus.tx_done = 1'b0;
    forever begin
      @(negedge Clk);
      if (bus.send_en === 1'b1 && tx_en) begin
        repeat (10) @(negedge Clk);
        bus.tx_done = 1'b1;
        @(negedge Clk);
        bus.tx_done = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic low_seen;
    logic [7:0] exp4 [6];
    exp4 = '{8'h91, 8'h01, 8'h91, 8'h02, 8'h91, 8'h03};

    cyc(3);
    chk("rst_key_state", key_state, 4'hF);
    chk("rst_level", fifo_level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_send_en", bus.send_en, 0);
    chk("rst_data", bus.data_byte, 0);
    Rst = 1'b0;
    cyc(2);

    // key2 press and release, event mode
    key_in[2] = 1'b0;
    n = 0;
    do begin cyc(1); n++; end while (key_state[2] && n < 50);
    chk("db_latency", n, 6);
    n = 0;
    do begin cyc(1); n++; end while (!bus.send_en && n < 50);
    chk("send_latency", n, 3);
    chk("press_byte", bus.data_byte, 8'h82);
    cyc(11);
    sent.delete();
    key_in[2] = 1'b1;
    cyc(30);
    chk("rel_count", sent.size(), 1);
    chk("rel_byte", get_byte(0), 8'h02);
    chk("rel_state", key_state[2], 1);

    // key1 bounce never settles
    sent.delete();
    low_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      key_in[1] = i[0];
      repeat (2) begin
        cyc(1);
        if (!key_state[1]) low_seen = 1'b1;
      end
    end
    key_in[1] = 1'b1;
    cyc(10);
    chk("bounce_state", low_seen, 0);
    chk("bounce_tx", sent.size(), 0);

    // keys 0 and 3 together
    sent.delete();
    max_lvl = 0;
    key_in = key_in & 4'b0110;
    cyc(40);
    chk("dual_count", sent.size(), 2);
    chk("dual_first", get_byte(0), 8'h80);
    chk("dual_second", get_byte(1), 8'h83);
    chk("dual_peak", (max_lvl >= 1 && max_lvl <= 2), 1);
    chk("dual_ovf", overflow, 0);
    key_in = key_in | 4'b1001;
    cyc(40);
    chk("dual_rel0", get_byte(2), 8'h00);
    chk("dual_rel3", get_byte(3), 8'h03);

    // count mode, three presses on key1
    mode = 1'b1;
    sent.delete();
    for (int i = 0; i < 3; i++) begin
      key_in[1] = 1'b0; cyc(12);
      key_in[1] = 1'b1; cyc(12);
    end
    cyc(60);
    chk("cnt_count", sent.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("cnt_byte%0d", i), get_byte(i), exp4[i]);

    sent.delete();
    cnt_clr = 1'b1; cyc(1); cnt_clr = 1'b0;
    key_in[1] = 1'b0; cyc(12);
    key_in[1] = 1'b1; cyc(40);
    chk("clr_count", sent.size(), 2);
    chk("clr_hdr", get_byte(0), 8'h91);
    chk("clr_cnt", get_byte(1), 8'h01);

    // FIFO fill and overflow with tx_done withheld
    mode = 1'b0;
    cyc(20);
    tx_en = 1'b0;
    sent.delete();
    for (int i = 0; i < 9; i++) begin
      key_in[0] = ~key_in[0];
      cyc(8);
    end
    cyc(4);
    chk("fill_level", fifo_level, 8);
    chk("fill_ovf", overflow, 0);
    for (int i = 0; i < 2; i++) begin
      key_in[0] = ~key_in[0];
      cyc(8);
    end
    cyc(4);
    chk("ovf_set", overflow, 1);
    chk("ovf_level", fifo_level, 8);
    cyc(20);
    chk("ovf_sticky", overflow, 1);
    chk("fill_sent", sent.size(), 1);

    key_in = 4'hF;
    tx_en = 1'b1;
    Rst = 1'b1;
    cyc(1);
    chk("midrst_send_en", bus.send_en, 0);
    chk("midrst_level", fifo_level, 0);
    chk("midrst_ovf", overflow, 0);
    chk("midrst_keys", key_state, 4'hF);
    Rst = 1'b0;
    sent.delete();
    cyc(20);
    chk("postrst_quiet", sent.size(), 0);

    // 256 presses on key0: count wraps to zero
    mode = 1'b1;
    sent.delete();
    for (int i = 0; i < 256; i++) begin
      key_in[0] = 1'b0; cyc(15);
      key_in[0] = 1'b1; cyc(15);
    end
    cyc(60);
    chk("wrap_count", sent.size(), 512);
    chk("wrap_first_hdr", get_byte(0), 8'h90);
    chk("wrap_first_cnt", get_byte(1), 8'h01);
    chk("wrap_255", get_byte(509), 8'hFF);
    chk("wrap_last_hdr", get_byte(510), 8'h90);
    chk("wrap_last_cnt", get_byte(511), 8'h00);
    chk("wrap_ovf", overflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
